// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - IF/LS arbiter serialising requests onto the byte-wide RAM/IO port
module mem_arbiter_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state, state_d;
  logic [31:0] base, base_d;
  logic [31:0] wdata, wdata_d;
  logic [2:0]  nbytes, nbytes_d;
  // read: cycles since grant; write: index of the byte currently on the bus
  logic [2:0]  cnt, cnt_d;
  logic        last_ls, last_ls_d;
  logic [31:0] mem_a_d;
  logic [7:0]  mem_dout_d;
  logic        mem_wr_d;
  logic        if_done_d, ls_done_d;
  logic [31:0] if_data_d, ls_rdata_d;

  logic [2:0]  ls_n;
  logic        req_open, if_ok, ls_ok, grant_ls, grant_if;
  logic [2:0]  wr_idx;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;
  logic [31:0] rd_next_addr;
  logic [1:0]  cap_idx;

  assign ls_n     = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
  // no new grant while a done pulse is still visible to the requesters
  assign req_open = !if_done && !ls_done;
  assign if_ok    = if_req && !flush && req_open;
  assign ls_ok    = ls_req && req_open;
  assign grant_ls = ls_ok && (!if_ok || !last_ls);
  assign grant_if = if_ok && !grant_ls;

  // a write driven last cycle with rdy_in high has landed, so move on to the next byte
  assign wr_idx       = mem_wr ? (cnt + 3'd1) : cnt;
  assign wr_addr      = base + {29'd0, wr_idx};
  assign wr_byte      = wdata[{wr_idx[1:0], 3'b000} +: 8];
  assign rd_next_addr = base + {29'd0, cnt} + 32'd1;
  assign cap_idx      = cnt[1:0] - 2'd1;

  // next-state and next-output computation, assuming the pipeline advances
  always_comb begin
    state_d    = state;
    base_d     = base;
    wdata_d    = wdata;
    nbytes_d   = nbytes;
    cnt_d      = cnt;
    last_ls_d  = last_ls;
    mem_a_d    = 32'h0;
    mem_dout_d = mem_dout;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data;
    ls_rdata_d = ls_rdata;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          last_ls_d = 1'b1;
          base_d    = ls_addr;
          wdata_d   = ls_wdata;
          nbytes_d  = ls_n;
          cnt_d     = 3'd0;
          mem_a_d   = ls_addr;
          if (ls_we) begin
            state_d    = LS_WR;
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = !((ls_addr >= IO_BASE) && io_buffer_full);
          end else begin
            state_d    = LS_RD;
            ls_rdata_d = 32'h0;
          end
        end else if (grant_if) begin
          last_ls_d = 1'b0;
          base_d    = if_addr;
          nbytes_d  = 3'd4;
          cnt_d     = 3'd0;
          mem_a_d   = if_addr;
          state_d   = IF_RD;
          if_data_d = 32'h0;
        end
      end
      IF_RD, LS_RD: begin
        if (state == IF_RD && flush) begin
          state_d = IDLE;
        end else begin
          if (cnt != 3'd0) begin
            if (state == IF_RD) if_data_d[{cap_idx, 3'b000} +: 8] = mem_din;
            else                ls_rdata_d[{cap_idx, 3'b000} +: 8] = mem_din;
          end
          if ((cnt + 3'd1) < nbytes) mem_a_d = rd_next_addr;
          if (cnt == nbytes) begin
            state_d = IDLE;
            if (state == IF_RD) if_done_d = 1'b1;
            else                ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      LS_WR: begin
        if (mem_wr && ((cnt + 3'd1) == nbytes)) begin
          state_d   = IDLE;
          ls_done_d = 1'b1;
        end else begin
          cnt_d      = wr_idx;
          mem_a_d    = wr_addr;
          mem_dout_d = wr_byte;
          mem_wr_d   = !((wr_addr >= IO_BASE) && io_buffer_full);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // register update; a pause freezes everything but withdraws any pending write strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      base     <= 32'h0;
      wdata    <= 32'h0;
      nbytes   <= 3'd0;
      cnt      <= 3'd0;
      last_ls  <= 1'b0;
      mem_a    <= 32'h0;
      mem_dout <= 8'h0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= 32'h0;
      ls_rdata <= 32'h0;
    end else if (!rdy_in) begin
      mem_wr <= 1'b0;
    end else begin
      state    <= state_d;
      base     <= base_d;
      wdata    <= wdata_d;
      nbytes   <= nbytes_d;
      cnt      <= cnt_d;
      last_ls  <= last_ls_d;
      mem_a    <= mem_a_d;
      mem_dout <= mem_dout_d;
      mem_wr   <= mem_wr_d;
      if_done  <= if_done_d;
      ls_done  <= ls_done_d;
      if_data  <= if_data_d;
      ls_rdata <= ls_rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Sits between the CPU core and the single byte-wide RAM/IO port of the top level.
- Arbitrates two requesters: instruction fetch (IF, always 32-bit reads) and load/store unit (LS, 8/16/32-bit reads and writes).
- Serialises each request into little-endian byte accesses and reassembles read data.
- Honours the global pause signal (rdy_in) and the UART output back-pressure (io_buffer_full).

Parameters:
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO; writes there obey io_buffer_full.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  1 = run; 0 = freeze all state
- io_buffer_full  in  1  UART TX buffer full
- mem_din  in  8  RAM/IO read data, valid the cycle after its address
- mem_dout  out  8  write data
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write, 0 = read
- flush  in  1  branch mispredict; cancels IF
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse
- if_data  out  32  fetched word, valid with if_done
- ls_req  in  1  LS request, held until ls_done
- ls_we  in  1  1 = store
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended, valid with ls_done

Behaviour:
- Reset values (all synchronous): state IDLE, mem_a = 0, mem_dout = 0, mem_wr = 0, if_done = 0, ls_done = 0, if_data = 0, ls_rdata = 0, last_grant = IF.
- States: IDLE, IF_RD, LS_RD, LS_WR. n = bytes (1/2/4; IF always 4). All outputs are registered.
- Grant (IDLE, request sampled in cycle T):
  - Only one pending: grant it.
  - Both pending: grant the one not granted last (round-robin).
  - flush = 1 in cycle T: if_req is ignored for that cycle.
- Read (IF_RD / LS_RD):
  - Cycle T+1+i (i = 0..n-1): mem_a = addr+i, mem_wr = 0.
  - Byte i is captured from mem_din at cycle T+2+i into bits [8i+7:8i].
  - Cycle T+n+2: done = 1, data valid, state back to IDLE.
- Write (LS_WR):
  - Cycle T+1+i: mem_a = addr+i, mem_wr = 1, mem_dout = ls_wdata[8i+7:8i].
  - The cycle after the last byte: ls_done = 1.
- IO stall:
  - Write byte whose address >= IO_BASE while io_buffer_full = 1: mem_wr = 0, mem_a held, byte index not advanced; retried each cycle.
  - Reads never stall; each IO read address is issued exactly once.
- Done-cycle turnaround: req inputs are not sampled in the cycle done = 1. Requesters drop or change req in that cycle. Minimum one idle cycle between operations.
- rdy_in = 0:
  - All registers hold, except mem_wr, which is forced to 0.
  - A byte counted as issued is re-issued after rdy_in returns to 1 only if its write had not yet been driven with rdy_in = 1.
  - Done pulses are held until the next cycle with rdy_in = 1.
- flush:
  - In IF_RD: abort; next state IDLE; no if_done. A late mem_din byte is discarded.
  - In LS_RD / LS_WR: ignored; the LS operation completes.
  - flush in the same cycle as if_done: if_done is still issued, and IF discards it.
- Byte addresses wrap modulo 2^32.
- Request inputs must be stable while in service. Their changes mid-operation are ignored except flush.
- rst_in mid-operation: immediate return to reset values. Partial writes are not undone.

Test Plan:
- IF only, if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00 → mem_a = 0x100..0x103 on consecutive cycles; if_done 6 cycles after the accept cycle (T+6); if_data = 0x00000513.
- LS byte store: ls_addr = 0x30000, data 0x41, io_buffer_full = 1 for 3 cycles → mem_wr stays 0 for 3 cycles, then exactly one write of 0x41 to 0x30000; ls_done the next cycle.
- if_req and ls_req both high in IDLE, last_grant = IF → LS load half at 0x200 (RAM = 34 12) served first, ls_rdata = 0x00001234. Then IF served; the alternation repeats.
- flush one cycle after an IF grant at 0x104 → no if_done. A following LS word load at 0x8 completes with correct data, and the stale byte is not merged.
- rdy_in = 0 for 2 cycles during a word store at 0x1000 of 0xDEADBEEF → mem_wr low while paused; RAM receives EF BE AD DE exactly once each.
- rst_in asserted during LS_WR → next cycle mem_wr = 0, mem_a = 0, state IDLE; a new IF request is accepted the cycle after reset deasserts.
